// File: rtl/mastermind_pkg.sv
// Shared types and helpers for the mastermind scorer: colour width, FSM state
// encoding, counter sizing and peg extraction from a packed code word.
package mastermind_pkg;

   localparam int COLOR_W    = 2;
   localparam int MAX_PEGS   = 8;
   localparam int MAX_CODE_W = COLOR_W * MAX_PEGS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXACT = 2'd1,
      CROSS = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Width that holds 0..n without wrapping.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic logic [COLOR_W-1:0] peg_slice(input logic [MAX_CODE_W-1:0] code,
                                                    input int                    idx);
      return code[COLOR_W*idx +: COLOR_W];
   endfunction

endpackage

// File: rtl/mastermind_scorer_comp2.sv
// Single 2-bit equality comparator shared by every peg comparison of the scorer.
module comp2
   import mastermind_pkg::*;
(
   input  logic [COLOR_W-1:0] a,
   input  logic [COLOR_W-1:0] b,
   output logic               a_eq_b
);

   assign a_eq_b = (a == b);

endmodule

// File: rtl/mastermind_scorer.sv
// Sequential mastermind scorer: exact pass then guess-by-secret cross pass over one
// shared comparator. Define MASTERMIND_SCORER_EARLY_EXIT_EN to skip the cross pass on a win.
module mastermind_scorer
   import mastermind_pkg::*;
#(
   parameter int N_PEGS = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [COLOR_W*N_PEGS-1:0]   secret,
   input  logic [COLOR_W*N_PEGS-1:0]   guess,
   output logic                        busy,
   output logic                        done,
   output logic [cnt_w(N_PEGS)-1:0]    exact_cnt,
   output logic [cnt_w(N_PEGS)-1:0]    color_cnt,
   output logic                        win
);

   localparam int CW     = cnt_w(N_PEGS);
   localparam int IDX_W  = $clog2(N_PEGS);
   localparam int CODE_W = COLOR_W * N_PEGS;

   state_e              state_q, state_d;
   logic [CODE_W-1:0]   sec_q, gss_q;
   logic [IDX_W-1:0]    g_q, s_q;
   logic [N_PEGS-1:0]   sec_used_q, gss_used_q;
   logic [CW-1:0]       exact_q, color_q;
   logic                win_q;

   logic [MAX_CODE_W-1:0] sec_ext, gss_ext;
   logic [COLOR_W-1:0]    cmp_a, cmp_b;
   logic                  eq;
   logic                  g_last, s_last;
   logic                  exact_hit, cross_credit;
   logic [CW-1:0]         exact_nxt;
   logic                  all_exact;

   assign sec_ext = MAX_CODE_W'(sec_q);
   assign gss_ext = MAX_CODE_W'(gss_q);
   assign g_last  = (g_q == IDX_W'(N_PEGS - 1));
   assign s_last  = (s_q == IDX_W'(N_PEGS - 1));

   // Exact pass compares sec[g]/gss[g]; cross pass compares gss[g]/sec[s].
   always_comb begin
      cmp_a = peg_slice(sec_ext, int'(g_q));
      cmp_b = peg_slice(gss_ext, int'(g_q));
      if (state_q == CROSS) begin
         cmp_a = peg_slice(gss_ext, int'(g_q));
         cmp_b = peg_slice(sec_ext, int'(s_q));
      end
   end

   comp2 u_comp2 (
      .a      (cmp_a),
      .b      (cmp_b),
      .a_eq_b (eq)
   );

   assign exact_hit    = (state_q == EXACT) && eq;
   assign cross_credit = (state_q == CROSS) && eq && !gss_used_q[g_q] && !sec_used_q[s_q];
   assign exact_nxt    = exact_q + CW'(exact_hit);
   assign all_exact    = (exact_nxt == CW'(N_PEGS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start) state_d = EXACT;
         EXACT: if (g_last) begin
`ifdef MASTERMIND_SCORER_EARLY_EXIT_EN
                   state_d = all_exact ? DONE : CROSS;
`else
                   state_d = CROSS;
`endif
                end
         CROSS: if (g_last && s_last) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == EXACT) || (state_q == CROSS);
      done = (state_q == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec_q      <= '0;
         gss_q      <= '0;
         g_q        <= '0;
         s_q        <= '0;
         sec_used_q <= '0;
         gss_used_q <= '0;
         exact_q    <= '0;
         color_q    <= '0;
         win_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               sec_q      <= secret;
               gss_q      <= guess;
               g_q        <= '0;
               s_q        <= '0;
               sec_used_q <= '0;
               gss_used_q <= '0;
               exact_q    <= '0;
               color_q    <= '0;
               win_q      <= 1'b0;
            end
            EXACT: begin
               if (exact_hit) begin
                  exact_q         <= exact_nxt;
                  sec_used_q[g_q] <= 1'b1;
                  gss_used_q[g_q] <= 1'b1;
               end
               g_q <= g_last ? '0 : g_q + IDX_W'(1);
            end
            CROSS: begin
               if (cross_credit) begin
                  color_q         <= color_q + CW'(1);
                  gss_used_q[g_q] <= 1'b1;
                  sec_used_q[s_q] <= 1'b1;
               end
               s_q <= s_last ? '0 : s_q + IDX_W'(1);
               if (s_last) g_q <= g_last ? '0 : g_q + IDX_W'(1);
            end
            default: ;
         endcase
         // win is captured on the way into DONE so it is valid alongside done.
         if (state_d == DONE && state_q != DONE) win_q <= all_exact;
      end
   end

   assign exact_cnt = exact_q;
   assign color_cnt = color_q;
   assign win       = win_q;

endmodule

// File: doc/mastermind_scorer.md
Name: mastermind_scorer

Overview:
- Sequential scoring engine for the mastermind game.
- Scores one guess against the secret code. It reports exact matches (right colour, right peg) and colour-only matches (right colour, wrong peg, with no double counting).
- It time-shares a single 2-bit equality comparator (comp2) across all peg pairs under a small FSM.
- It sits between the guess-entry logic and the display/game-control logic.

Parameters:
- N_PEGS, default 4: pegs per code. Range 2..8.

Ports:
- clk  input  1: system clock, rising edge.
- rst_n  input  1: asynchronous active-low reset.
- start  input  1: begin scoring. Sampled only in IDLE.
- secret  input  2*N_PEGS: secret code. Peg i is at bits [2i+1:2i].
- guess  input  2*N_PEGS: player guess, packed the same way.
- busy  output  1: high while scoring.
- done  output  1: one-cycle pulse when results are valid.
- exact_cnt  output  $clog2(N_PEGS+1): exact-match count.
- color_cnt  output  $clog2(N_PEGS+1): colour-only match count.
- win  output  1: exact_cnt == N_PEGS. Updated with done.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, done, exact_cnt, color_cnt and win are all 0.
  - Internal indices and used-masks are cleared.
- IDLE:
  - On start=1 at clock edge k, secret and guess are latched into internal registers. Inputs may change afterwards.
  - The index and both used-masks are cleared. exact_cnt and color_cnt are cleared to 0.
  - Go to EXACT. busy=1 from k+1.
- EXACT (N_PEGS cycles, i = 0..N_PEGS-1):
  - The comparator sees sec[i] and gss[i].
  - On a match: exact_cnt++, sec_used[i]=1, gss_used[i]=1.
- CROSS (N_PEGS*N_PEGS cycles, g outer, s inner, both 0..N_PEGS-1):
  - The comparator sees gss[g] and sec[s].
  - Credit only if: match, !gss_used[g], !sec_used[s], and the pair is not exact (g != s is implied by the masks).
  - On credit: color_cnt++, gss_used[g]=1, sec_used[s]=1.
  - Skipped pairs still consume one cycle, so latency is fixed.
- DONE (1 cycle):
  - done=1, busy=0. win is registered from the final exact_cnt. Then go to IDLE.
- Latency: start sampled at k gives done at k+N_PEGS+N_PEGS²+1 (k+21 for N_PEGS=4).
- exact_cnt, color_cnt and win hold their values after done until the next accepted start.
- Invariant: exact_cnt+color_cnt ≤ N_PEGS.
- start while busy or in DONE: ignored, no restart.
- start held high continuously: a new scoring begins on the first IDLE cycle after DONE.
- Reset mid-operation: immediate abort to IDLE. All outputs go to 0 and no done is issued.
- Counter widths: sized so N_PEGS never wraps. Loop indices wrap to 0 at the end of each phase.

Optional Feature:
- Macro: MASTERMIND_SCORER_EARLY_EXIT_EN.
- Defined: if exact_cnt==N_PEGS at the end of EXACT, CROSS is skipped and the FSM goes straight to DONE. done occurs at k+N_PEGS+1 (k+5 for N_PEGS=4). Non-winning guesses keep full latency.
- Undefined: fixed latency for every guess.

Decomposition:
- Package mastermind_pkg:
  - COLOR_W=2 and the peg-slice helper.
  - State enum {IDLE, EXACT, CROSS, DONE}.
  - Count width function for N_PEGS.
- Sub-module: exactly one existing comp2 instance (a, b → a_eq_b), fed by muxes from the FSM indices. No other comparators are permitted.

Test Plan:
- secret=8'hE4 (pegs 0,1,2,3), guess=8'hE4, start at k → done at k+21; exact_cnt=4, color_cnt=0, win=1.
- secret=8'hE4, guess=8'h1B (pegs 3,2,1,0) → exact_cnt=0, color_cnt=4, win=0, done at k+21.
- secret=8'h00, guess=8'h50 (pegs 0,0,1,1) → exact_cnt=2, color_cnt=0 (no double count of 0s).
- Duplicates: secret=8'hE5 (1,1,2,3), guess=8'h56 (2,1,1,1) → exact_cnt=1, color_cnt=2.
- Abort cases:
  - start re-pulsed at k+5 → ignored, a single done at k+21.
  - Separate run: rst_n low at k+10 → busy, done and counts go to 0 asynchronously, with no done afterwards.
  - A new start after release scores correctly.
- With MASTERMIND_SCORER_EARLY_EXIT_EN: the case-1 stimulus gives done at k+5, win=1; the case-2 stimulus still gives done at k+21.
